// File: rtl/reg_ctrl_pkg.sv
// Shared types for the register-bank write controller: FSM states and default data width.
package reg_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of eligible scanning from ptr upward, wrapping.
// Purely combinational, no handshake.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  int w_idx;

  // Walk offsets high-to-low so the smallest offset from ptr is written last and wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(ptr) + k) % NREQ;
      if (eligible[w_idx]) begin
        winner = PW'(w_idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Write-port controller: zero-sweeps the register bank after reset, then issues one
// round-robin-arbitrated write per cycle; outputs registered one edge after req sample.
module reg_write_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NREGS = 8,
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREGS-1:0]      reg_en,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state;
  logic [AW-1:0]     r_clr_cnt;
  logic [PW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [NREGS-1:0]  r_reg_en;
  logic [WIDTH-1:0]  r_reg_d;

  state_t            w_state_nxt;
  logic [AW-1:0]     w_clr_cnt_nxt;
  logic [PW-1:0]     w_ptr_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [NREGS-1:0]  w_en_nxt;
  logic [WIDTH-1:0]  w_d_nxt;

  logic [NREQ-1:0]   w_eligible;
  logic [PW-1:0]     w_win;
  logic              w_win_vld;
  logic [AW-1:0]     w_win_addr;
  logic [WIDTH-1:0]  w_win_data;
  logic              w_addr_ok;

  // A requester granted last edge sits out one cycle so held requests alternate fairly.
  assign w_eligible = req & ~r_gnt;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .eligible (w_eligible),
    .ptr      (r_ptr),
    .winner   (w_win),
    .valid    (w_win_vld)
  );

  assign w_win_addr = req_addr[w_win*AW +: AW];
  assign w_win_data = req_data[w_win*WIDTH +: WIDTH];
  assign w_addr_ok  = (32'(w_win_addr) < NREGS);

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = '0;
    w_en_nxt      = '0;
    w_d_nxt       = r_reg_d;
    case (r_state)
      CLEAR: begin
        w_en_nxt[r_clr_cnt] = 1'b1;
        w_d_nxt             = '0;
        w_clr_cnt_nxt       = r_clr_cnt + 1'b1;
        if (r_clr_cnt == AW'(NREGS - 1))
          w_state_nxt = ARB;
      end
      ARB: begin
        if (w_win_vld) begin
          w_gnt_nxt[w_win] = 1'b1;
          // Out-of-range addresses are still acked but the write is dropped.
          if (w_addr_ok)
            w_en_nxt[w_win_addr] = 1'b1;
          w_d_nxt   = w_win_data;
          w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_reg_en  <= '0;
      r_reg_d   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_reg_en  <= w_en_nxt;
      r_reg_d   <= w_d_nxt;
    end
  end

  assign gnt    = r_gnt;
  assign reg_en = r_reg_en;
  assign reg_d  = r_reg_d;
  assign busy   = (r_state == CLEAR);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: an 8-register instance and a 6-register instance.
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-register instance
  logic         rst;
  logic [3:0]   req;
  logic [11:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic [7:0]   reg_en;
  logic [31:0]  reg_d;
  logic         busy;

  // 6-register instance
  logic         rst6;
  logic [3:0]   req6;
  logic [11:0]  req_addr6;
  logic [127:0] req_data6;
  logic [3:0]   gnt6;
  logic [5:0]   reg_en6;
  logic [31:0]  reg_d6;
  logic         busy6;

  int n_checks = 0;
  int n_errors = 0;

  reg_write_arbiter #(.NREQ(4), .NREGS(8), .WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .reg_en   (reg_en),
    .reg_d    (reg_d),
    .busy     (busy)
  );

  reg_write_arbiter #(.NREQ(4), .NREGS(6), .WIDTH(32)) dut6 (
    .clk      (clk),
    .rst      (rst6),
    .req      (req6),
    .req_addr (req_addr6),
    .req_data (req_data6),
    .gnt      (gnt6),
    .reg_en   (reg_en6),
    .reg_d    (reg_d6),
    .busy     (busy6)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [3:0] eg, input logic [7:0] een,
                        input logic [31:0] ed, input logic eb);
    check({tag, ".gnt"},    64'(gnt),    64'(eg));
    check({tag, ".reg_en"}, 64'(reg_en), 64'(een));
    check({tag, ".reg_d"},  64'(reg_d),  64'(ed));
    check({tag, ".busy"},   64'(busy),   64'(eb));
  endtask

  task automatic check6(input string tag, input logic [3:0] eg, input logic [5:0] een,
                        input logic [31:0] ed, input logic eb);
    check({tag, ".gnt"},    64'(gnt6),    64'(eg));
    check({tag, ".reg_en"}, 64'(reg_en6), 64'(een));
    check({tag, ".reg_d"},  64'(reg_d6),  64'(ed));
    check({tag, ".busy"},   64'(busy6),   64'(eb));
  endtask

  logic [3:0] exp_seq [6];

  initial begin
    rst = 1'b1;  req  = '0; req_addr  = '0; req_data  = '0;
    rst6 = 1'b1; req6 = '0; req_addr6 = '0; req_data6 = '0;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001; exp_seq[5] = 4'b0010;
    #1;
    check8("reset", 4'b0, 8'h00, 32'h0, 1'b1);
    check6("reset6", 4'b0, 6'h00, 32'h0, 1'b1);

    // req[2] held through the whole sweep must not be granted until ARB
    req[2] = 1'b1;
    req_addr[2*3 +: 3]   = 3'd6;
    req_data[2*32 +: 32] = 32'h1234_5678;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      check8($sformatf("sweep%0d", i), 4'b0, 8'(1 << i), 32'h0, (i < 7) ? 1'b1 : 1'b0);
    end
    tick;
    check8("first_gnt", 4'b0100, 8'h40, 32'h1234_5678, 1'b0);
    tick;
    check8("held_masked", 4'b0000, 8'h00, 32'h1234_5678, 1'b0);
    req = '0;

    // single pulse from requester 0 (ptr now 3, wraps to 0)
    req[0] = 1'b1;
    req_addr[0 +: 3]  = 3'd3;
    req_data[0 +: 32] = 32'hBA09_F533;
    tick;
    check8("pulse_gnt", 4'b0001, 8'h08, 32'hBA09_F533, 1'b0);
    req = '0;
    tick;
    check8("pulse_idle", 4'b0000, 8'h00, 32'hBA09_F533, 1'b0);

    // requester 3 pulse moves ptr back to 0
    req[3] = 1'b1;
    req_addr[3*3 +: 3]   = 3'd0;
    req_data[3*32 +: 32] = 32'h0000_0033;
    tick;
    check8("r3_gnt", 4'b1000, 8'h01, 32'h0000_0033, 1'b0);
    req = '0;
    tick;
    check8("r3_idle", 4'b0000, 8'h00, 32'h0000_0033, 1'b0);

    // all four held: strict rotation, never the same requester twice in a row
    for (int i = 0; i < 4; i++) begin
      req_addr[i*3 +: 3]   = 3'(i + 1);
      req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick;
      check8($sformatf("rot%0d", c), exp_seq[c], 8'(1 << ((c % 4) + 1)),
             32'hA000_0000 + 32'(c % 4), 1'b0);
    end
    req = '0;
    tick;
    check8("rot_idle", 4'b0000, 8'h00, 32'hA000_0001, 1'b0);

    // same address from 1 and 3 with ptr=2: 3 first, then 1 is the surviving value
    req_addr[1*3 +: 3]   = 3'd5;
    req_data[1*32 +: 32] = 32'h7887_BA09;
    req_addr[3*3 +: 3]   = 3'd5;
    req_data[3*32 +: 32] = 32'hFFFF_FFFF;
    req = 4'b1010;
    tick;
    check8("same_a", 4'b1000, 8'h20, 32'hFFFF_FFFF, 1'b0);
    req = 4'b0010;
    tick;
    check8("same_b", 4'b0010, 8'h20, 32'h7887_BA09, 1'b0);
    req = '0;
    tick;
    check8("same_end", 4'b0000, 8'h00, 32'h7887_BA09, 1'b0);

    // 6-register instance: reset pulsed mid-sweep, then restart from register 0
    rst6 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check6($sformatf("s6a_%0d", i), 4'b0, 6'(1 << i), 32'h0, 1'b1);
    end
    rst6 = 1'b1;
    #1;
    check6("mid_rst", 4'b0, 6'h00, 32'h0, 1'b1);
    tick;
    rst6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check6($sformatf("s6b_%0d", i), 4'b0, 6'(1 << i), 32'h0, (i < 5) ? 1'b1 : 1'b0);
    end

    // out-of-range address: acked, no enable, ptr still advances
    req_addr6[0 +: 3]  = 3'd7;
    req_data6[0 +: 32] = 32'hAAAA_5555;
    req6 = 4'b0001;
    tick;
    check6("oor", 4'b0001, 6'h00, 32'hAAAA_5555, 1'b0);
    req_addr6[1*3 +: 3]   = 3'd2;
    req_data6[1*32 +: 32] = 32'h0000_1111;
    req6 = 4'b0011;
    tick;
    check6("oor_ptr", 4'b0010, 6'h04, 32'h0000_1111, 1'b0);
    req6 = '0;
    tick;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Write-port controller for a bank of `reg32` registers in the 32-bit processor datapath. Arbitrates round-robin between `NREQ` requesters, each presenting an address and 32-bit word, and drives one shared data bus plus a one-hot enable per register. After reset it sequences a clear sweep that writes zero to every register before accepting requests. At most one register write is issued per cycle.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `NREGS`, 8: number of `reg32` registers driven (2..32)
- `WIDTH`, 32: data width
- `AW`, `$clog2(NREGS)`: address width (derived; not overridden)

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `req`  in  NREQ  request bit per requester
- `req_addr`  in  NREQ*AW  packed addresses, requester i at `[i*AW +: AW]`
- `req_data`  in  NREQ*WIDTH  packed data, requester i at `[i*WIDTH +: WIDTH]`
- `gnt`  out  NREQ  one-hot grant/ack, registered
- `reg_en`  out  NREGS  one-hot write enable to register bank, registered
- `reg_d`  out  WIDTH  shared write data to register bank, registered
- `busy`  out  1  high while clear sweep is in progress

## Operation
- States: `CLEAR`, `ARB`. Reset forces `CLEAR`, `clr_cnt`=0, `ptr`=0.
- `CLEAR`: each edge issues `reg_en`=1<<`clr_cnt`, `reg_d`=0, `gnt`=0, then `clr_cnt`++. On the edge issuing `clr_cnt`=NREGS-1, next state `ARB`. `req` ignored entirely; no grant generated, no request queued.
- `ARB`: eligible = `req` & ~`gnt` (a requester granted this cycle is masked for one cycle). Pick first eligible index scanning `ptr`, `ptr`+1, …, wrapping modulo NREQ. On the edge: `gnt`=1<<winner, `reg_en`=1<<addr(winner), `reg_d`=data(winner), `ptr`=(winner+1) mod NREQ. No eligible requester: `gnt`=0, `reg_en`=0, `reg_d` holds, `ptr` holds.
- Address ≥ NREGS (non-power-of-two NREGS): grant still issued, `ptr` advances, `reg_en`=0 (write dropped).
- Same address from several requesters: serialized by arbitration; last grant wins in the register.
- `busy` = (state == `CLEAR`), decoded from the state register.

## Timing
- Reset values (async, immediate): `gnt`=0, `reg_en`=0, `reg_d`=0, `busy`=1.
- Clear sweep: writes issued at edges 1..NREGS after `rst` falls; `busy` falls at edge NREGS. The first request sampled is at edge NREGS+1.
- Request latency: `req` sampled at edge k → `gnt`/`reg_en`/`reg_d` valid during cycle k..k+1 → register captures at edge k+1.
- Requester contract: on seeing `gnt[i]`=1, drop `req[i]` or present a new addr/data. A held request is re-eligible one cycle later and is written again.
- Maximum throughput: one write per cycle in aggregate; one write per requester every 2 cycles.
- `rst` mid-sweep or mid-arbitration: outputs clear immediately. The sweep restarts from register 0 on release. An in-flight write is lost.

## Structure
- Shared package `reg_ctrl_pkg`: state enum (`CLEAR`, `ARB`), `WIDTH` default 32 constant.
- Sub-module `rr_pick`: combinational; takes `eligible[NREQ]` and `ptr`, returns winner index and a `valid` bit. The top level holds all registers, the FSM and the address decode.

## Test plan
- Reset release, NREGS=8, `req`=0 → `reg_en` = 0x01,0x02,…,0x80 on 8 consecutive cycles with `reg_d`=0. `busy` falls with the 0x80 write. `reg_en`=0 after.
- `req[2]`=1 throughout sweep → no `gnt` during `CLEAR`. First `gnt`=4'b0100 one cycle after `busy` falls.
- `ARB`, single pulse `req[0]`, addr 3, data 32'hBA09F533 → next cycle `gnt`=4'b0001, `reg_en`=8'h08, `reg_d`=32'hBA09F533. Following cycle `gnt`=0, `reg_en`=0.
- All four `req` held high, `ptr`=0 → `gnt` sequence 0001,0010,0100,1000,0001… with no repeated requester in adjacent cycles.
- `req[1]`,addr 5,32'h7887BA09 and `req[3]`,addr 5,32'hFFFFFFFF same cycle, `ptr`=2 → `req[3]` granted first, then `req[1]`. `reg_d` ends at 32'h7887BA09.
- NREGS=6: request with addr 7 → `gnt` asserted, `reg_en`=0. `rst` pulsed at sweep step 3 → outputs zero immediately, sweep restarts at `reg_en`=0x01.
